order_tx: RTL and testbench

- Downstream end of the trading path: consumes the per-sample buy/sell decision from the trade logic unit.
- Applies a position limit and a cooldown to each decision.
- Encodes each accepted decision into a 6-byte order frame.
- Streams the frame out one byte per beat over a valid/ready byte interface toward the exchange-side transmitter.

---
 rtl/order_pkg.sv | 16 +
 rtl/order_frame_mux.sv | 31 +++
 rtl/order_tx.sv | 180 ++++++++++++++++++
 tb/tb_order_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_pkg.sv
// Shared types and constants for the order transmit path: FSM states,
// side codes and frame geometry.
package order_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_e;

   localparam logic [7:0] SIDE_BUY  = 8'h01;
   localparam logic [7:0] SIDE_SELL = 8'h02;
   localparam int         FRAME_LEN = 6;
   localparam int         IDX_W     = 3;

endpackage

// File: rtl/order_frame_mux.sv
// Combinational frame byte selector: picks byte idx of the 6-byte order
// frame and computes the trailing XOR checksum over bytes 0..4.
module order_frame_mux
   import order_pkg::*;
#(
   parameter logic [7:0] HDR_BYTE  = 8'hA5,
   parameter logic [7:0] ORDER_QTY = 8'd1
) (
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       side,
   input  logic [7:0]       price,
   input  logic [7:0]       seq,
   output logic [7:0]       byte_out
);

   logic [7:0] checksum;

   always_comb begin
      checksum = HDR_BYTE ^ side ^ price ^ ORDER_QTY ^ seq;
      case (idx)
         3'd0:    byte_out = HDR_BYTE;
         3'd1:    byte_out = side;
         3'd2:    byte_out = price;
         3'd3:    byte_out = ORDER_QTY;
         3'd4:    byte_out = seq;
         3'd5:    byte_out = checksum;
         default: byte_out = 8'h00;
      endcase
   end

endmodule

// File: rtl/order_tx.sv
// Order transmitter: position-limits and cools down trade decisions, then
// streams each accepted decision as a 6-byte frame over a valid/ready byte port.
module order_tx
   import order_pkg::*;
#(
   parameter logic        [7:0] ORDER_QTY    = 8'd1,
   parameter logic signed [7:0] MAX_POS      = 8'sd16,
   parameter int                COOLDOWN_CYC = 16,
   parameter logic        [7:0] HDR_BYTE     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_valid_end,
   input  logic       buy_signal,
   input  logic       sell_signal,
   input  logic [7:0] price,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic [7:0] position,
   output logic [7:0] seq_num,
   output logic [7:0] reject_count
);

   localparam logic [15:0]      CD_LOAD  = 16'(COOLDOWN_CYC);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_e                  state_q, state_d;
   logic                    tx_valid_q, tx_valid_d;
   logic                    busy_q, busy_d;
   logic signed [7:0]       position_q, position_d;
   logic [7:0]              seq_num_q, seq_num_d;
   logic [7:0]              reject_count_q, reject_count_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [15:0]             cd_cnt_q, cd_cnt_d;
   logic [7:0]              side_q, side_d;
   logic [7:0]              price_q, price_d;
   logic [7:0]              fseq_q, fseq_d;

   logic signed [8:0]       pos9, qty9, max9;
   logic                    buy_ok, sell_ok, handshake, has_dec, reject;
   logic [7:0]              frame_byte;

   // Limit tests run one bit wider so +/-MAX_POS edges cannot overflow.
   always_comb begin
      pos9    = {position_q[7], position_q};
      qty9    = {1'b0, ORDER_QTY};
      max9    = {MAX_POS[7], MAX_POS};
      buy_ok  = (pos9 + qty9) <= max9;
      sell_ok = (pos9 - qty9) >= -max9;
   end

   always_comb begin
      state_d        = state_q;
      tx_valid_d     = tx_valid_q;
      position_d     = position_q;
      seq_num_d      = seq_num_q;
      reject_count_d = reject_count_q;
      idx_d          = idx_q;
      cd_cnt_d       = cd_cnt_q;
      side_d         = side_q;
      price_d        = price_q;
      fseq_d         = fseq_q;
      reject         = 1'b0;
      handshake      = tx_valid_q && tx_ready;
      has_dec        = data_valid_end && (buy_signal || sell_signal);

      case (state_q)
         ST_IDLE: begin
            if (data_valid_end) begin
               if (buy_signal && !sell_signal && buy_ok) begin
                  side_d     = SIDE_BUY;
                  position_d = position_q + $signed(ORDER_QTY);
                  state_d    = ST_SEND;
               end else if (sell_signal && !buy_signal && sell_ok) begin
                  side_d     = SIDE_SELL;
                  position_d = position_q - $signed(ORDER_QTY);
                  state_d    = ST_SEND;
               end else if (buy_signal || sell_signal) begin
                  reject = 1'b1;
               end
               if (state_d == ST_SEND) begin
                  price_d    = price;
                  fseq_d     = seq_num_q;
                  idx_d      = '0;
                  tx_valid_d = 1'b1;
               end
            end
         end
         ST_SEND: begin
            reject = has_dec;
            if (handshake) begin
               if (idx_q == LAST_IDX) begin
                  idx_d      = '0;
                  tx_valid_d = 1'b0;
                  seq_num_d  = seq_num_q + 8'd1;
                  if (CD_LOAD == 16'd0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d  = ST_COOLDOWN;
                     cd_cnt_d = CD_LOAD;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_COOLDOWN: begin
            reject = has_dec;
            // Leaving on the count of 1 makes IDLE land exactly CD_LOAD edges after the last byte.
            if (cd_cnt_q <= 16'd1) begin
               cd_cnt_d = 16'd0;
               state_d  = ST_IDLE;
            end else begin
               cd_cnt_d = cd_cnt_q - 16'd1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            idx_d      = '0;
            cd_cnt_d   = 16'd0;
         end
      endcase

      if (reject && (reject_count_q != 8'hFF)) begin
         reject_count_d = reject_count_q + 8'd1;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         tx_valid_q     <= 1'b0;
         busy_q         <= 1'b0;
         position_q     <= 8'sd0;
         seq_num_q      <= 8'd0;
         reject_count_q <= 8'd0;
         idx_q          <= '0;
         cd_cnt_q       <= 16'd0;
      end else begin
         state_q        <= state_d;
         tx_valid_q     <= tx_valid_d;
         busy_q         <= busy_d;
         position_q     <= position_d;
         seq_num_q      <= seq_num_d;
         reject_count_q <= reject_count_d;
         idx_q          <= idx_d;
         cd_cnt_q       <= cd_cnt_d;
      end
   end

   // Frame payload is only observed while tx_valid is high, so it needs no reset.
   always_ff @(posedge clk) begin
      side_q  <= side_d;
      price_q <= price_d;
      fseq_q  <= fseq_d;
   end

   order_frame_mux #(
      .HDR_BYTE  (HDR_BYTE),
      .ORDER_QTY (ORDER_QTY)
   ) u_frame_mux (
      .idx      (idx_q),
      .side     (side_q),
      .price    (price_q),
      .seq      (fseq_q),
      .byte_out (frame_byte)
   );

   assign tx_data      = tx_valid_q ? frame_byte : 8'h00;
   assign tx_valid     = tx_valid_q;
   assign busy         = busy_q;
   assign position     = position_q;
   assign seq_num      = seq_num_q;
   assign reject_count = reject_count_q;

endmodule

// File: tb/tb_order_tx.sv
// Scoreboard bench for order_tx: directed decisions push expected frame bytes,
// a negedge monitor pops and compares them on every byte handshake.
module tb_order_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       dv = 1'b0;
   logic       buy = 1'b0;
   logic       sell = 1'b0;
   logic       tx_ready = 1'b1;
   logic [7:0] price = 8'h00;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       busy;
   logic [7:0] position;
   logic [7:0] seq_num;
   logic [7:0] reject_count;

   int         checks = 0;
   int         errors = 0;
   int         hs_count = 0;
   logic [7:0] exp_q[$];

   int         m_pos = 0;
   logic [7:0] m_seq = 8'h00;
   logic [7:0] m_rej = 8'h00;

   logic       held_v = 1'b0;
   logic [7:0] held_b = 8'h00;

   always #5 clk = ~clk;

   order_tx #(
      .ORDER_QTY    (8'd1),
      .MAX_POS      (8'sd16),
      .COOLDOWN_CYC (16),
      .HDR_BYTE     (8'hA5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_valid_end (dv),
      .buy_signal     (buy),
      .sell_signal    (sell),
      .price          (price),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .busy           (busy),
      .position       (position),
      .seq_num        (seq_num),
      .reject_count   (reject_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares each handshaked byte and checks holding while stalled.
   always @(negedge clk) begin
      if (!rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) chk("hold_valid", {31'd0, tx_valid}, 32'd1);
         if (tx_valid) begin
            if (held_v) chk("hold_data", {24'd0, tx_data}, {24'd0, held_b});
            if (tx_ready) begin
               hs_count++;
               held_v = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte got %0h expected none at %0t", tx_data, $time);
               end else begin
                  chk("frame_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
               end
            end else begin
               held_v = 1'b1;
               held_b = tx_data;
            end
         end else begin
            held_v = 1'b0;
         end
      end
   end

   task automatic push_frame(input logic [7:0] side, input logic [7:0] p);
      logic [7:0] cs;
      cs = 8'hA5 ^ side ^ p ^ 8'h01 ^ m_seq;
      exp_q.push_back(8'hA5);
      exp_q.push_back(side);
      exp_q.push_back(p);
      exp_q.push_back(8'h01);
      exp_q.push_back(m_seq);
      exp_q.push_back(cs);
      m_seq = m_seq + 8'd1;
   endtask

   task automatic model_reject();
      if (m_rej != 8'hFF) m_rej = m_rej + 8'd1;
   endtask

   // Strobe one decision; in_busy tells the model the DUT is in SEND/COOLDOWN.
   task automatic decide(input logic b, input logic s, input logic [7:0] p, input logic in_busy);
      @(posedge clk);
      #1;
      dv = 1'b1; buy = b; sell = s; price = p;
      if ((b ^ s) && !in_busy) begin
         if (b && (m_pos + 1 <= 16)) begin
            push_frame(8'h01, p);
            m_pos = m_pos + 1;
         end else if (s && (m_pos - 1 >= -16)) begin
            push_frame(8'h02, p);
            m_pos = m_pos - 1;
         end else begin
            model_reject();
         end
      end else if (b || s) begin
         model_reject();
      end
      @(posedge clk);
      #1;
      dv = 1'b0; buy = 1'b0; sell = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= bound) chk({name, "_timeout"}, n, 0);
   endtask

   task automatic check_state(input string name);
      logic [7:0] mp;
      mp = 8'(m_pos);
      chk({name, "_position"}, {24'd0, position}, {24'd0, mp});
      chk({name, "_seq_num"}, {24'd0, seq_num}, {24'd0, m_seq});
      chk({name, "_reject_count"}, {24'd0, reject_count}, {24'd0, m_rej});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_pos = 0; m_seq = 8'h00; m_rej = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hs0;
      logic rpat [4];
      rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      check_state("rst");
      rst = 1'b1;

      // Single buy at price 0x64, ready high: bytes A5,01,64,01,00,C1 on N+1..N+6
      decide(1'b1, 1'b0, 8'h64, 1'b0);
      chk("t1_first_valid", {31'd0, tx_valid}, 32'd1);
      for (int i = 1; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("t1_valid_run", {31'd0, tx_valid}, 32'd1);
      end
      @(posedge clk);
      #1;
      chk("t1_valid_drop", {31'd0, tx_valid}, 32'd0);
      wait_idle("t1", 100);
      check_state("t1");

      // Sell with ready toggling 1,0,0,1
      hs0 = hs_count;
      decide(1'b0, 1'b1, 8'h37, 1'b0);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         tx_ready = rpat[n % 4];
         n++;
      end
      tx_ready = 1'b1;
      wait_idle("t2", 100);
      chk("t2_handshakes", hs_count - hs0, 6);
      check_state("t2");

      // Conflicting buy+sell: rejected, no frame
      decide(1'b1, 1'b1, 8'h50, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("t3_no_valid", {31'd0, tx_valid}, 32'd0);
      end
      check_state("t3");

      // Position limit: 16 buys fill, 17th rejected, sell accepted
      do_reset();
      for (int i = 0; i < 16; i++) begin
         decide(1'b1, 1'b0, 8'(i + 8'h20), 1'b0);
         wait_idle("t4_fill", 100);
      end
      check_state("t4_full");
      decide(1'b1, 1'b0, 8'h77, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_limit_no_valid", {31'd0, tx_valid}, 32'd0);
      check_state("t4_reject");
      decide(1'b0, 1'b1, 8'h78, 1'b0);
      wait_idle("t4_sell", 100);
      check_state("t4_sell");

      // Strobes during SEND and 3 cycles into COOLDOWN are rejected
      do_reset();
      decide(1'b1, 1'b0, 8'h10, 1'b0);
      decide(1'b1, 1'b0, 8'h11, 1'b1);
      n = 0;
      while (tx_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk("t5_frame_timeout", n, 0);
      @(posedge clk);
      decide(1'b0, 1'b1, 8'h12, 1'b1);
      n = 3;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t5_cooldown_len", n, 16);
      check_state("t5_rejects");
      decide(1'b0, 1'b1, 8'h13, 1'b0);
      chk("t5_accept_valid", {31'd0, tx_valid}, 32'd1);
      wait_idle("t5", 100);
      check_state("t5_accept");

      // Reset asserted while byte 2 is presented
      decide(1'b1, 1'b0, 8'h22, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("t6_async_valid", {31'd0, tx_valid}, 32'd0);
      chk("t6_async_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      m_pos = 0; m_seq = 8'h00; m_rej = 8'h00;
      check_state("t6_in_reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      decide(1'b1, 1'b0, 8'h22, 1'b0);
      wait_idle("t6", 100);
      check_state("t6_after");

      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
